// File: rtl/dp_transition_scheduler_pkg.sv
// Shared types and constants for the dining-philosophers transition scheduler.
// Net indices: place 2i = thinking(i), 2i+1 = eating(i); forks i, (i+1)%N.
package dp_transition_scheduler_pkg;

  localparam int N_PHIL = 5;
  localparam int NT     = 2 * N_PHIL;
  localparam int NP     = 2 * N_PHIL;
  localparam int KW     = $clog2(NT);
  localparam int PW     = $clog2(N_PHIL);

  localparam logic [NP-1:0]     MARK_RST = 10'b0101010101;
  localparam logic [N_PHIL-1:0] FORK_RST = '1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FIRE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  function automatic logic [PW-1:0] left_fork(
    input logic [PW-1:0] i
  );
    return i;
  endfunction

  function automatic logic [PW-1:0] right_fork(
    input logic [PW-1:0] i
  );
    return (i == PW'(N_PHIL - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/dp_transition_scheduler_if.sv
// Request / fire / marking bundle between the scheduler and its neighbours.
// master = request and ack side, slave = scheduler.
interface dp_transition_scheduler_if;
  import dp_transition_scheduler_pkg::*;

  logic [N_PHIL-1:0] req_eat;
  logic [N_PHIL-1:0] req_done;
  logic              ack;
  logic [NT-1:0]     t;
  logic              en;
  logic              data;
  logic [NP-1:0]     marking;
  logic [N_PHIL-1:0] forks;
  logic              err_timeout;

  modport master (
    output req_eat, req_done, ack,
    input  t, en, data, marking, forks, err_timeout
  );

  modport slave (
    input  req_eat, req_done, ack,
    output t, en, data, marking, forks, err_timeout
  );

endinterface

// File: rtl/dp_transition_scheduler_arb.sv
// Rotate-priority arbiter over the transition enables.
// The search starts at i_ptr and wraps from NT-1 back to 0.
module dp_transition_scheduler_arb
  import dp_transition_scheduler_pkg::*;
(
  input  logic [NT-1:0] i_req,
  input  logic [KW-1:0] i_ptr,
  output logic [NT-1:0] o_grant,
  output logic [KW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int n = 0; n < NT; n++) begin
      if (!o_valid && i_req[(int'(i_ptr) + n) % NT]) begin
        o_valid = 1'b1;
        o_grant[(int'(i_ptr) + n) % NT] = 1'b1;
        o_idx = KW'((int'(i_ptr) + n) % NT);
      end
    end
  end

endmodule

// File: rtl/dp_transition_scheduler.sv
// Owns the philosopher Petri-net marking and fires one enabled
// transition at a time toward the MSFSM side, 4-phase acked.
module dp_transition_scheduler
  import dp_transition_scheduler_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TW          = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  dp_transition_scheduler_if.slave   bus
);

  state_t            r_state;
  state_t            w_next;
  logic [NP-1:0]     r_mark;
  logic [N_PHIL-1:0] r_forks;
  logic [NT-1:0]     r_t;
  logic [NT-1:0]     r_gnt;
  logic              r_en;
  logic              r_data;
  logic              r_err;
  logic [KW-1:0]     r_ptr;
  logic [KW-1:0]     r_k;
  logic [TW-1:0]     r_cnt;

  logic [NT-1:0]     w_enabled;
  logic [NT-1:0]     w_grant;
  logic [KW-1:0]     w_idx;
  logic              w_any;
  logic              w_wait;
  logic              w_exit_ok;
  logic              w_tmo;
  logic [PW-1:0]     w_phil;

  for (genvar g = 0; g < N_PHIL; g++) begin : g_en
    assign w_enabled[2*g] = r_mark[2*g]
                          & r_forks[g]
                          & r_forks[(g+1) % N_PHIL]
                          & bus.req_eat[g];
    assign w_enabled[2*g+1] = r_mark[2*g+1]
                            & bus.req_done[g];
  end

  dp_transition_scheduler_arb u_arb (
    .i_req   (w_enabled),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign w_phil    = r_k[KW-1:1];
  assign w_wait    = (r_state == WAIT_HI)
                   || (r_state == WAIT_LO);
  assign w_exit_ok = ((r_state == WAIT_HI) && bus.ack)
                   || ((r_state == WAIT_LO) && !bus.ack);
  assign w_tmo     = w_wait && !w_exit_ok
                   && (r_cnt == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any && !bus.ack) w_next = SELECT;
      SELECT:  w_next = w_any ? FIRE : IDLE;
      FIRE:    w_next = WAIT_HI;
      WAIT_HI: begin
        if (bus.ack)    w_next = WAIT_LO;
        else if (w_tmo) w_next = IDLE;
      end
      WAIT_LO: begin
        if (!bus.ack)   w_next = IDLE;
        else if (w_tmo) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mark  <= MARK_RST;
      r_forks <= FORK_RST;
      r_t     <= '0;
      r_gnt   <= '0;
      r_en    <= 1'b0;
      r_data  <= 1'b0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state != w_next)
        r_cnt <= '0;
      else if (w_wait && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;

      if (r_state == SELECT && w_any) begin
        r_k   <= w_idx;
        r_gnt <= w_grant;
      end

      // marking commits on the same edge en rises, so it is stable under en
      if (r_state == FIRE) begin
        r_mark[{w_phil, 1'b0}]       <= r_k[0];
        r_mark[{w_phil, 1'b1}]       <= ~r_k[0];
        r_forks[left_fork(w_phil)]  <= r_k[0];
        r_forks[right_fork(w_phil)] <= r_k[0];
        r_t    <= r_gnt;
        r_en   <= 1'b1;
        r_data <= r_k[0];
        r_ptr  <= (r_k == KW'(NT - 1)) ? '0 : r_k + 1'b1;
      end

      if (r_state == WAIT_HI && (bus.ack || w_tmo)) begin
        r_t  <= '0;
        r_en <= 1'b0;
      end

      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign bus.t           = r_t;
  assign bus.en          = r_en;
  assign bus.data        = r_data;
  assign bus.marking     = r_mark;
  assign bus.forks       = r_forks;
  assign bus.err_timeout = r_err;

endmodule
